// File: rtl/msg_frame_pkg.sv
// Shared types and header layout constants for the framed message sender.
package msg_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEXT,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_WAIT_EMPTY,
    ST_LOAD,
    ST_GUARD,
    ST_DONE
  } state_t;

  localparam int HDR_BYTES  = 8;
  localparam int OFS_SYNC   = 0;
  localparam int OFS_TOTAL  = 2;
  localparam int OFS_MSG_ID = 4;
  localparam int OFS_SEQ    = 6;
  localparam int CSUM_W     = 8;

  // 16-bit fields go out LSB first: even offset = low byte.
  function automatic logic [7:0] field_byte(input logic [15:0] field, input logic hi);
    return hi ? field[15:8] : field[7:0];
  endfunction

endpackage

// File: rtl/msg_frame_hdr_mux.sv
// Selects the header byte for a given index, or the checksum byte when the
// trailer is being sent.
module msg_frame_hdr_mux
  import msg_frame_pkg::*;
#(
  parameter logic [15:0] MSG_ID    = 16'd100,
  parameter logic [15:0] SYNC_WORD = 16'h1234
) (
  input  logic [2:0]        byte_idx,
  input  logic              sel_csum,
  input  logic [15:0]       total,
  input  logic [15:0]       seq_number,
  input  logic [CSUM_W-1:0] csum,
  output logic [7:0]        hdr_byte
);

  always_comb begin
    hdr_byte = '0;
    if (sel_csum) begin
      hdr_byte = csum;
    end else begin
      case (byte_idx[2:1])
        2'(OFS_SYNC / 2):   hdr_byte = field_byte(SYNC_WORD, byte_idx[0]);
        2'(OFS_TOTAL / 2):  hdr_byte = field_byte(total, byte_idx[0]);
        2'(OFS_MSG_ID / 2): hdr_byte = field_byte(MSG_ID, byte_idx[0]);
        2'(OFS_SEQ / 2):    hdr_byte = field_byte(seq_number, byte_idx[0]);
        default:            hdr_byte = '0;
      endcase
    end
  end

endmodule

// File: rtl/msg_frame_sender.sv
// Builds one framed message (header, optional RAM payload, optional checksum)
// and hands it byte by byte to the P2S serializer.
//
//   state         | meaning
//   --------------+-----------------------------------------------------
//   ST_IDLE       | Ready=1, waiting for Send
//   ST_NEXT       | classify current byte index (header/csum vs payload)
//   ST_FETCH      | RamRead strobe for payload byte idx-8
//   ST_FETCH_WAIT | RAM data returns, captured at end of cycle
//   ST_WAIT_EMPTY | hold until serializer reports empty
//   ST_LOAD       | LoadByte strobe, checksum accumulate, idx++
//   ST_GUARD      | settle cycle, P2S_Empty ignored; finish or loop
//   ST_DONE       | Done pulse, back to idle
module msg_frame_sender
  import msg_frame_pkg::*;
#(
  parameter logic [15:0] MSG_ID      = 16'd100,
  parameter logic [15:0] SYNC_WORD   = 16'h1234,
  parameter int          MAX_PAYLOAD = 256,
  parameter int          CHECKSUM_EN = 0,
  parameter int          LEN_W       = (MAX_PAYLOAD > 0) ? $clog2(MAX_PAYLOAD + 1) : 1,
  parameter int          ADDR_W      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Send,
  input  logic [15:0]       SeqNumber,
  input  logic [LEN_W-1:0]  PayloadLen,
  input  logic              P2S_Empty,
  input  logic [7:0]        RamData,
  output logic              Ready,
  output logic              Done,
  output logic              LoadByte,
  output logic [7:0]        MsgByte,
  output logic              RamRead,
  output logic [ADDR_W-1:0] RamAddr
);

  state_t              state_q, state_d;
  logic [15:0]         idx_q;
  logic [15:0]         total_q;
  logic [15:0]         pay_end_q;
  logic [15:0]         seq_q;
  logic [CSUM_W-1:0]   csum_q;
  logic [7:0]          payload_q;

  logic                ready_q, done_q, load_q, rd_q;
  logic [7:0]          msg_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [15:0]         len_c;
  logic                is_hdr, is_csum;
  logic [7:0]          hdr_byte, cur_byte;

  // Oversized requests are silently clamped to the payload capacity.
  always_comb begin
    len_c = 16'(PayloadLen);
    if (32'(PayloadLen) > 32'(MAX_PAYLOAD))
      len_c = 16'(MAX_PAYLOAD);
  end

  always_comb begin
    is_hdr   = (idx_q < 16'(HDR_BYTES));
    is_csum  = (CHECKSUM_EN != 0) && (idx_q == pay_end_q);
    cur_byte = (is_hdr || is_csum) ? hdr_byte : payload_q;
  end

  msg_frame_hdr_mux #(
    .MSG_ID    (MSG_ID),
    .SYNC_WORD (SYNC_WORD)
  ) u_hdr_mux (
    .byte_idx   (idx_q[2:0]),
    .sel_csum   (is_csum),
    .total      (total_q),
    .seq_number (seq_q),
    .csum       (csum_q),
    .hdr_byte   (hdr_byte)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (Send) state_d = ST_NEXT;
      ST_NEXT:       state_d = (is_hdr || is_csum) ? ST_WAIT_EMPTY : ST_FETCH;
      ST_FETCH:      state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: state_d = ST_WAIT_EMPTY;
      ST_WAIT_EMPTY: if (P2S_Empty) state_d = ST_LOAD;
      ST_LOAD:       state_d = ST_GUARD;
      ST_GUARD:      state_d = (idx_q == total_q) ? ST_DONE : ST_NEXT;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      total_q   <= '0;
      pay_end_q <= '0;
      seq_q     <= '0;
      csum_q    <= '0;
      payload_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      rd_q      <= 1'b0;
      msg_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      load_q  <= (state_d == ST_LOAD);
      rd_q    <= (state_d == ST_FETCH);

      if (state_q == ST_IDLE && Send) begin
        seq_q     <= SeqNumber;
        pay_end_q <= 16'(HDR_BYTES) + len_c;
        total_q   <= 16'(HDR_BYTES) + len_c + 16'(CHECKSUM_EN);
        idx_q     <= '0;
        csum_q    <= '0;
      end

      if (state_d == ST_FETCH)
        addr_q <= ADDR_W'(idx_q - 16'(HDR_BYTES));

      if (state_q == ST_FETCH_WAIT)
        payload_q <= RamData;

      if (state_q == ST_WAIT_EMPTY && state_d == ST_LOAD)
        msg_q <= cur_byte;

      if (state_q == ST_LOAD) begin
        csum_q <= csum_q + msg_q;
        idx_q  <= idx_q + 16'd1;
      end
    end
  end

  assign Ready    = ready_q;
  assign Done     = done_q;
  assign LoadByte = load_q;
  assign MsgByte  = msg_q;
  assign RamRead  = rd_q;
  assign RamAddr  = addr_q;

endmodule

// File: tb/tb_msg_frame_sender.sv
// Directed bench for msg_frame_sender: one instance without and one with the
// checksum trailer, driven in lockstep from a shared stimulus.
module tb_msg_frame_sender;

  localparam int MAXP   = 256;
  localparam int LEN_W  = 9;
  localparam int ADDR_W = 8;

  logic              Clock, Clear, Send, P2S_Empty;
  logic [15:0]       SeqNumber;
  logic [LEN_W-1:0]  PayloadLen;
  logic [7:0]        RamData0, RamData1;
  logic              Ready0, Done0, LoadByte0, RamRead0;
  logic              Ready1, Done1, LoadByte1, RamRead1;
  logic [7:0]        MsgByte0, MsgByte1;
  logic [ADDR_W-1:0] RamAddr0, RamAddr1;

  logic [7:0] ram [MAXP];
  logic [7:0] q0[$], q1[$];
  int         lc0[$], rd0[$];
  int         done0, done1, cyc;
  int         vectors, miscompares;

  msg_frame_sender #(.MAX_PAYLOAD(MAXP), .CHECKSUM_EN(0)) dut0 (
    .Clock(Clock), .Clear(Clear), .Send(Send), .SeqNumber(SeqNumber),
    .PayloadLen(PayloadLen), .P2S_Empty(P2S_Empty), .RamData(RamData0),
    .Ready(Ready0), .Done(Done0), .LoadByte(LoadByte0), .MsgByte(MsgByte0),
    .RamRead(RamRead0), .RamAddr(RamAddr0));

  msg_frame_sender #(.MAX_PAYLOAD(MAXP), .CHECKSUM_EN(1)) dut1 (
    .Clock(Clock), .Clear(Clear), .Send(Send), .SeqNumber(SeqNumber),
    .PayloadLen(PayloadLen), .P2S_Empty(P2S_Empty), .RamData(RamData1),
    .Ready(Ready1), .Done(Done1), .LoadByte(LoadByte1), .MsgByte(MsgByte1),
    .RamRead(RamRead1), .RamAddr(RamAddr1));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (RamRead0) RamData0 <= ram[RamAddr0];
    if (RamRead1) RamData1 <= ram[RamAddr1];
  end

  // Recorder samples 1 time unit after the edge.
  always @(posedge Clock) begin
    cyc++;
    #1;
    if (LoadByte0) begin q0.push_back(MsgByte0); lc0.push_back(cyc); end
    if (LoadByte1) q1.push_back(MsgByte1);
    if (RamRead0) rd0.push_back(int'(RamAddr0));
    if (Done0) done0++;
    if (Done1) done1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_msg(input string tag, input logic [7:0] got[$], input int base,
                           input logic [7:0] exp[$]);
    check({tag, "_len"}, 32'(got.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < got.size())
        check($sformatf("%s_b%0d", tag, i), 32'(got[base + i]), 32'(exp[i]));
      else
        check($sformatf("%s_b%0d", tag, i), 32'hFFFF_FFFF, 32'(exp[i]));
    end
  endtask

  task automatic send(input logic [15:0] seq, input logic [LEN_W-1:0] len, output int sc);
    @(negedge Clock);
    Send = 1'b1; SeqNumber = seq; PayloadLen = len;
    sc = cyc;
    @(negedge Clock);
    Send = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (Ready0 && Ready1) break;
      @(negedge Clock);
    end
    check({tag, "_idle"}, 32'(Ready0 && Ready1), 32'd1);
  endtask

  task automatic wait_loads(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q0.size() >= n) break;
      @(negedge Clock);
    end
    check({tag, "_reach"}, 32'(q0.size() >= n), 32'd1);
  endtask

  logic [7:0] e0[$], e1[$];
  int b0, b1, r0, d0, d1, sc, n0;
  logic [7:0] sum;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; done0 = 0; done1 = 0;
    Clear = 1'b1; Send = 1'b0; SeqNumber = '0; PayloadLen = '0; P2S_Empty = 1'b1;
    RamData0 = '0; RamData1 = '0;
    for (int i = 0; i < MAXP; i++) ram[i] = 8'(i * 7 + 3);
    ram[0] = 8'hAA; ram[1] = 8'hBB; ram[2] = 8'hCC;

    repeat (3) @(negedge Clock);
    Clear = 1'b0;
    @(negedge Clock);
    check("rst_ready",   32'(Ready0),    32'd1);
    check("rst_done",    32'(Done0),     32'd0);
    check("rst_load",    32'(LoadByte0), 32'd0);
    check("rst_msgbyte", 32'(MsgByte0),  32'd0);
    check("rst_ramread", 32'(RamRead0),  32'd0);
    check("rst_ramaddr", 32'(RamAddr0),  32'd0);

    // Header only
    b0 = q0.size(); b1 = q1.size(); d0 = done0; d1 = done1; r0 = rd0.size();
    send(16'h0102, 9'd0, sc);
    wait_idle("hdr", 200);
    e0 = '{8'h34, 8'h12, 8'h08, 8'h00, 8'h64, 8'h00, 8'h02, 8'h01};
    e1 = '{8'h34, 8'h12, 8'h09, 8'h00, 8'h64, 8'h00, 8'h02, 8'h01, 8'hB6};
    check_msg("hdr0", q0, b0, e0);
    check_msg("hdr1", q1, b1, e1);
    check("hdr_first_lat", 32'(lc0[b0] - sc), 32'd3);
    check("hdr_spacing",   32'(lc0[b0 + 1] - lc0[b0]), 32'd4);
    check("hdr_done0",     32'(done0 - d0), 32'd1);
    check("hdr_done1",     32'(done1 - d1), 32'd1);
    check("hdr_no_reads",  32'(rd0.size() - r0), 32'd0);

    // Three-byte payload
    b0 = q0.size(); b1 = q1.size(); r0 = rd0.size();
    send(16'h0005, 9'd3, sc);
    wait_idle("pay", 300);
    e0 = '{8'h34, 8'h12, 8'h0B, 8'h00, 8'h64, 8'h00, 8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    e1 = '{8'h34, 8'h12, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hEC};
    check_msg("pay0", q0, b0, e0);
    check_msg("pay1", q1, b1, e1);
    check("pay_nreads", 32'(rd0.size() - r0), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("pay_addr%0d", i), 32'(rd0[r0 + i]), 32'(i));
    check("pay_spacing", 32'(lc0[b0 + 8] - lc0[b0 + 7]), 32'd6);

    // Backpressure before byte 3
    b0 = q0.size(); b1 = q1.size(); r0 = rd0.size();
    send(16'h0005, 9'd3, sc);
    wait_loads("bp", b0 + 3, 100);
    P2S_Empty = 1'b0;
    n0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (LoadByte0 || MsgByte0 !== 8'h0B) n0++;
    end
    check("bp_held", 32'(n0), 32'd0);
    check("bp_msgbyte", 32'(MsgByte0), 32'h0B);
    P2S_Empty = 1'b1;
    @(negedge Clock);
    check("bp_resume", 32'(LoadByte0), 32'd1);
    wait_idle("bp", 300);
    check_msg("bp0", q0, b0, e0);
    check_msg("bp1", q1, b1, e1);
    check("bp_nreads", 32'(rd0.size() - r0), 32'd3);

    // Oversized length clamps to 256; a mid-message Send is ignored
    b0 = q0.size(); b1 = q1.size(); r0 = rd0.size(); d0 = done0;
    send(16'hBEEF, 9'd300, sc);
    wait_loads("clamp", b0 + 20, 200);
    @(negedge Clock);
    Send = 1'b1; SeqNumber = 16'hFFFF; PayloadLen = 9'd0;
    @(negedge Clock);
    Send = 1'b0;
    wait_idle("clamp", 3000);
    e0 = '{8'h34, 8'h12, 8'h08, 8'h01, 8'h64, 8'h00, 8'hEF, 8'hBE};
    e1 = '{8'h34, 8'h12, 8'h09, 8'h01, 8'h64, 8'h00, 8'hEF, 8'hBE};
    for (int i = 0; i < MAXP; i++) begin
      e0.push_back(ram[i]);
      e1.push_back(ram[i]);
    end
    sum = '0;
    foreach (e1[i]) sum += e1[i];
    e1.push_back(sum);
    check_msg("clamp0", q0, b0, e0);
    check_msg("clamp1", q1, b1, e1);
    check("clamp_nreads", 32'(rd0.size() - r0), 32'd256);
    check("clamp_last_addr", 32'(rd0[rd0.size() - 1]), 32'd255);
    check("clamp_done", 32'(done0 - d0), 32'd1);
    repeat (10) @(negedge Clock);
    check("clamp_no_extra", 32'(q0.size() - b0), 32'd264);

    // Clear while fetching payload byte 1
    b0 = q0.size();
    send(16'h0007, 9'd3, sc);
    wait_loads("clr", b0 + 9, 100);
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    check("clr_ready0", 32'(Ready0), 32'd1);
    check("clr_ready1", 32'(Ready1), 32'd1);
    b0 = q0.size(); b1 = q1.size(); r0 = rd0.size();
    repeat (20) @(negedge Clock);
    check("clr_no_load0", 32'(q0.size() - b0), 32'd0);
    check("clr_no_load1", 32'(q1.size() - b1), 32'd0);
    check("clr_no_read",  32'(rd0.size() - r0), 32'd0);

    // Send and Clear together: Clear wins
    @(negedge Clock);
    Send = 1'b1; Clear = 1'b1; SeqNumber = 16'h0001; PayloadLen = 9'd0;
    @(negedge Clock);
    Send = 1'b0; Clear = 1'b0;
    check("sc_ready", 32'(Ready0), 32'd1);
    repeat (10) @(negedge Clock);
    check("sc_no_load", 32'(q0.size() - b0), 32'd0);

    // Fresh message after the abandoned one
    b0 = q0.size(); b1 = q1.size();
    send(16'h0009, 9'd3, sc);
    wait_idle("re", 300);
    e0 = '{8'h34, 8'h12, 8'h0B, 8'h00, 8'h64, 8'h00, 8'h09, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    e1 = '{8'h34, 8'h12, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h09, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hF0};
    check_msg("re0", q0, b0, e0);
    check_msg("re1", q1, b1, e1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msg_frame_sender.md
Name: msg_frame_sender

Overview:
Parametrised successor to the header-only message sender. Builds and serialises one complete framed message into the P2S serializer: an 8-byte header (sync word, byte count, message ID, sequence number), an optional payload of 0..MAX_PAYLOAD bytes read from an external sync-read RAM, and an optional 8-bit checksum. It sits between the messaging controller (Send/Ready) and the P2S serializer (LoadByte/MsgByte/P2S_Empty).

Parameters:
MSG_ID, 100, 16-bit message ID placed in header bytes 4-5.
SYNC_WORD, 16'h1234, 16-bit sync placed in header bytes 0-1.
MAX_PAYLOAD, 256, maximum payload bytes; 0 builds a header-only sender.
CHECKSUM_EN, 0, 1 = append checksum byte after the payload.
LEN_W, $clog2(MAX_PAYLOAD+1), PayloadLen width.
ADDR_W, $clog2(MAX_PAYLOAD) (min 1), RamAddr width.

Ports:
Clock  in  1  system clock
Clear  in  1  synchronous active-high reset
Send  in  1  start request, sampled only when Ready=1
SeqNumber  in  16  sequence number, latched on accepted Send
PayloadLen  in  LEN_W  payload byte count, latched on accepted Send
P2S_Empty  in  1  serializer can accept a byte
RamData  in  8  payload byte, valid 1 cycle after RamRead
Ready  out  1  idle and able to accept Send
Done  out  1  one-cycle pulse after last byte loaded
LoadByte  out  1  one-cycle load strobe to P2S
MsgByte  out  8  byte to P2S, valid while LoadByte=1
RamRead  out  1  RAM read strobe
RamAddr  out  ADDR_W  payload address, 0-based

Behaviour:
- One clock (Clock); Clear synchronous, active-high. All outputs registered.
- Reset values: Ready=1, Done=0, LoadByte=0, MsgByte=0, RamRead=0, RamAddr=0; state IDLE, byte index=0, checksum=0.
- Accepted Send (IDLE, Send=1): latch SeqNumber; latch Len=min(PayloadLen, MAX_PAYLOAD); Ready=0 from the next cycle. Send while busy is ignored.
- Total = 8 + Len + CHECKSUM_EN (16-bit, unsigned, no overflow at the default parameters).
- Byte order, all 16-bit fields LSB first: [0,1] SYNC_WORD; [2,3] Total; [4,5] MSG_ID; [6,7] SeqNumber; [8..8+Len-1] RAM[0..Len-1]; [Total-1] checksum if enabled.
- Checksum = mod-256 sum of every preceding byte of the message.
- States:
  - IDLE: accept Send, then go to NEXT.
  - NEXT: byte index < 8, or the checksum byte -> WAIT_EMPTY; payload byte -> FETCH.
  - FETCH: RamRead=1 for one cycle, RamAddr=idx-8 -> FETCH_WAIT.
  - FETCH_WAIT: capture RamData -> WAIT_EMPTY.
  - WAIT_EMPTY: hold until P2S_Empty=1 -> LOAD.
  - LOAD: LoadByte=1 with MsgByte; accumulate checksum; idx++ -> GUARD.
  - GUARD: one cycle, P2S_Empty ignored. If idx==Total -> DONE, else -> NEXT.
  - DONE: Done=1 for one cycle; Ready=1 next cycle; IDLE.
- Latency with P2S_Empty held at 1:
  - First LoadByte is 3 cycles after the Send cycle.
  - Header/checksum bytes repeat every 4 cycles; payload bytes every 6 cycles.
- Backpressure: P2S_Empty=0 holds WAIT_EMPTY indefinitely. MsgByte holds its value; no RAM re-read.
- Len=0: payload states are skipped; Total=8+CHECKSUM_EN.
- PayloadLen>MAX_PAYLOAD: clamp to MAX_PAYLOAD. No error flag.
- Clear in any state: IDLE next cycle, all outputs at reset values, no further LoadByte or RamRead, partial message abandoned.
- Send and Clear in the same cycle: Clear wins; Send is dropped.

Decomposition:
- Package msg_frame_pkg holds: state enum; HDR_BYTES=8; header field offset constants; checksum width.
- One natural sub-module: msg_frame_hdr_mux. It is combinational and, from the byte index, Total, SeqNumber and the checksum, selects the header/checksum byte. The FSM and counters stay in the top level.

Test Plan:
- Header-only, MSG_ID=100, SeqNumber=16'h0102, CHECKSUM_EN=0, P2S_Empty=1 -> bytes 34 12 08 00 64 00 02 01; first LoadByte 3 cycles after Send; Done once; Ready back.
- Same, CHECKSUM_EN=1 -> 34 12 09 00 64 00 02 01 B6.
- PayloadLen=3, RAM[0..2]=AA BB CC, Seq=0005, CHECKSUM_EN=0 -> 34 12 0B 00 64 00 05 00 AA BB CC; RamRead at addresses 0,1,2 only.
- P2S_Empty held low 10 cycles before byte 3 -> no LoadByte, MsgByte stable; resumes within 1 cycle of Empty=1; byte stream identical.
- PayloadLen=300, MAX_PAYLOAD=256 -> count bytes 08 01 (264); 256 RAM reads; Send pulsed mid-message is ignored.
- Clear asserted during payload byte 1 -> Ready=1 next cycle, no further LoadByte; a new Send then yields a full correct message.
